// File: rtl/atcbmc200_slv_arb_pkg.sv
// Shared types and helpers for the bus-matrix slave-port arbiter.
package atcbmc200_slv_arb_pkg;

    localparam int unsigned NUM_MST  = 4;
    localparam int unsigned MST_ID_W = $clog2(NUM_MST);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_e;

    // Address-phase grant bundle kept as one register
    typedef struct packed {
        logic [NUM_MST-1:0]  vec;
        logic [MST_ID_W-1:0] id;
        logic                vld;
    } arb_gnt_t;

    // Next master index with wrap, so the just-granted master drops to lowest priority
    function automatic logic [MST_ID_W-1:0] mst_inc(input logic [MST_ID_W-1:0] id);
        return (32'(id) == NUM_MST - 1) ? '0 : id + MST_ID_W'(1);
    endfunction

endpackage

// File: rtl/atcbmc200_slv_arb_if.sv
// Master-side request / arbiter grant bundle for one slave port of the bus matrix.
interface atcbmc200_slv_arb_if;
    import atcbmc200_slv_arb_pkg::*;

    logic [NUM_MST-1:0]  req;
    logic [NUM_MST-1:0]  seq;
    logic [NUM_MST-1:0]  last;
    logic [NUM_MST-1:0]  lock;
    logic                hready;
    logic [NUM_MST-1:0]  gnt;
    logic [MST_ID_W-1:0] gnt_id;
    logic                gnt_vld;
    logic [MST_ID_W-1:0] dat_id;
    logic                dat_vld;

    modport master (
        output req, seq, last, lock, hready,
        input  gnt, gnt_id, gnt_vld, dat_id, dat_vld
    );

    modport slave (
        input  req, seq, last, lock, hready,
        output gnt, gnt_id, gnt_vld, dat_id, dat_vld
    );

endinterface

// File: rtl/atcbmc200_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
module atcbmc200_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_win_c,
    output logic [ID_W-1:0] o_win_id_c,
    output logic            o_any_c
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_win_c    = '0;
        o_win_id_c = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = ID_W'((32'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_win_id_c     = w_idx;
                o_win_c[w_idx] = 1'b1;
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/atcbmc200_slv_arb.sv
// Per-slave-port arbiter: round-robin between bursts, grant held through bursts and locked sequences.
// Optional ATCBMC200_ARB_PARK_EN parks the grant on the last owner when nobody requests.
module atcbmc200_slv_arb
    import atcbmc200_slv_arb_pkg::*;
(
    input  logic               hclk,
    input  logic               hreset,
    atcbmc200_slv_arb_if.slave bus
);

    arb_state_e          r_state, w_state_nxt;
    logic [MST_ID_W-1:0] r_ptr, w_ptr_nxt;
    arb_gnt_t            r_gnt, w_gnt_nxt;
    logic                r_dat_vld, w_dat_vld_nxt;
    logic [MST_ID_W-1:0] r_dat_id, w_dat_id_nxt;

    logic [NUM_MST-1:0]  w_active;
    logic [NUM_MST-1:0]  w_win;
    logic [MST_ID_W-1:0] w_win_id;
    logic                w_any;
    logic                w_own_lock;
    logic                w_release;
    logic                w_rearb;

    assign w_active = bus.req | bus.seq;

    // ptr always sits one past the current owner, so the owner competes last on release
    atcbmc200_rr_pick #(
        .N    (NUM_MST),
        .ID_W (MST_ID_W)
    ) u_pick (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_win_c    (w_win),
        .o_win_id_c (w_win_id),
        .o_any_c    (w_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_dat_vld_nxt = 1'b0;
        w_dat_id_nxt  = r_dat_id;
        w_rearb       = 1'b0;
        w_own_lock    = bus.lock[r_gnt.id];
        w_release     = !w_own_lock && (!w_active[r_gnt.id] || bus.last[r_gnt.id]);

        unique case (r_state)
            ARB_IDLE: w_rearb = w_any;
            ARB_OWN: begin
                if (w_own_lock)     w_state_nxt = ARB_LOCK;
                else if (w_release) w_rearb     = 1'b1;
            end
            ARB_LOCK: begin
                if (!w_own_lock) begin
                    if (w_release) w_rearb     = 1'b1;
                    else           w_state_nxt = ARB_OWN;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase

        if (w_rearb) begin
            if (w_any) begin
                w_gnt_nxt   = '{vec: w_win, id: w_win_id, vld: 1'b1};
                w_ptr_nxt   = mst_inc(w_win_id);
                w_state_nxt = ARB_OWN;
            end else begin
`ifdef ATCBMC200_ARB_PARK_EN
                w_state_nxt = ARB_OWN;
`else
                w_gnt_nxt   = '0;
                w_state_nxt = ARB_IDLE;
`endif
            end
        end

        // Data phase follows an accepted address phase of the granted master
        if (r_gnt.vld && w_active[r_gnt.id]) begin
            w_dat_vld_nxt = 1'b1;
            w_dat_id_nxt  = r_gnt.id;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_dat_vld <= 1'b0;
            r_dat_id  <= '0;
        end else if (bus.hready) begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_dat_vld <= w_dat_vld_nxt;
            r_dat_id  <= w_dat_id_nxt;
        end
    end

    assign bus.gnt     = r_gnt.vec;
    assign bus.gnt_id  = r_gnt.id;
    assign bus.gnt_vld = r_gnt.vld;
    assign bus.dat_vld = r_dat_vld;
    assign bus.dat_id  = r_dat_id;

endmodule
